// File: rtl/uart_rx.sv
// uart_rx - serial UART receiver.
//
// Deserialises an idle-high, LSB-first serial line into a byte. Frame is one start
// bit, 7 or 8 data bits, an optional odd/even parity bit and one stop bit. The bit
// time in clocks comes from baud_count_i; every bit is sampled at its centre.
//
// Ports:
//   clk_i          system clock
//   rst_i          asynchronous, active-high reset
//   rx_i           serial input (asynchronous to clk_i)
//   baud_count_i   clocks per bit time (>= 4, stable during a frame)
//   eight_i        1 = 8 data bits, 0 = 7 data bits
//   pen_i          parity enable
//   ohel_i         parity sense: 1 = odd, 0 = even
//   rxrdy_clr_i    read acknowledge; clears rxrdy_o and all status flags
//   rx_data_o      received byte (bit 7 = 0 in 7-bit mode)
//   rxrdy_o        byte available
//   perr_o         parity error on the last frame
//   ferr_o         framing error (stop bit sampled low)
//   ovf_o          a frame completed while rxrdy_o was still set
module uart_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_i,
    input  logic [19:0] baud_count_i,
    input  logic        eight_i,
    input  logic        pen_i,
    input  logic        ohel_i,
    input  logic        rxrdy_clr_i,
    output logic [7:0]  rx_data_o,
    output logic        rxrdy_o,
    output logic        perr_o,
    output logic        ferr_o,
    output logic        ovf_o
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBrk
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;

    logic [19:0] cnt_q, cnt_d;
    logic [19:0] limit;
    logic        tick;
    logic [3:0]  bit_q, bit_d;
    logic [3:0]  nbits;
    logic [8:0]  shift_q, shift_d;
    logic [8:0]  frame;
    logic [7:0]  data8;
    logic        par_rx;
    logic        par_exp;
    logic        done;

    logic [7:0] rx_data_q, rx_data_d;
    logic       rxrdy_q, rxrdy_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;
    logic       ovf_q, ovf_d;

    // Synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    // Half a bit time in START lands every later sample at mid-bit.
    assign limit = (state_q == StStart) ? (baud_count_i >> 1) : baud_count_i;
    assign tick  = (cnt_q == limit - 20'd1);
    assign nbits = (eight_i ? 4'd8 : 4'd7) + {3'b000, pen_i};

    // Bits enter at bit 8 and shift down, so after nbits samples the frame occupies
    // the top nbits positions; shift it back down to right-justify.
    assign frame   = shift_q >> (4'd9 - nbits);
    assign data8   = eight_i ? frame[7:0] : {1'b0, frame[6:0]};
    assign par_rx  = eight_i ? frame[8] : frame[7];
    assign par_exp = (^data8) ^ ohel_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done    = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rxs) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                cnt_d = tick ? 20'd0 : cnt_q + 20'd1;
                if (tick) begin
                    if (!rxs) begin
                        state_d = StData;
                        bit_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                cnt_d = tick ? 20'd0 : cnt_q + 20'd1;
                if (tick) begin
                    shift_d = {rxs, shift_q[8:1]};
                    bit_d   = bit_q + 4'd1;
                    if (bit_q + 4'd1 == nbits) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                cnt_d = tick ? 20'd0 : cnt_q + 20'd1;
                if (tick) begin
                    done    = 1'b1;
                    state_d = rxs ? StIdle : StBrk;
                end
            end
            StBrk: begin
                // Hold off until the line returns high so a break is not a new start.
                cnt_d = '0;
                if (rxs) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Frame completion takes priority over a coincident clear; ovf uses pre-clear rxrdy.
    always_comb begin
        rx_data_d = rx_data_q;
        rxrdy_d   = rxrdy_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        ovf_d     = ovf_q;
        if (done) begin
            rx_data_d = data8;
            rxrdy_d   = 1'b1;
            perr_d    = pen_i & (par_rx != par_exp);
            ferr_d    = ~rxs;
            ovf_d     = ovf_q | rxrdy_q;
        end else if (rxrdy_clr_i) begin
            rxrdy_d = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            rxrdy_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            rxrdy_q   <= rxrdy_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
        end
    end

    assign rx_data_o = rx_data_q;
    assign rxrdy_o   = rxrdy_q;
    assign perr_o    = perr_q;
    assign ferr_o    = ferr_q;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx - directed self-checking bench for uart_rx.
// Inputs change on the falling clock edge; outputs are sampled on the falling edge.
module tb_uart_rx;

    logic        clk;
    logic        rst;
    logic        rx;
    logic [19:0] baud_count;
    logic        eight;
    logic        pen;
    logic        ohel;
    logic        rxrdy_clr;
    logic [7:0]  rx_data;
    logic        rxrdy;
    logic        perr;
    logic        ferr;
    logic        ovf;

    int n_cmp = 0;
    int n_err = 0;

    uart_rx #(
        .SYNC_STAGES(2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rx_i        (rx),
        .baud_count_i(baud_count),
        .eight_i     (eight),
        .pen_i       (pen),
        .ohel_i      (ohel),
        .rxrdy_clr_i (rxrdy_clr),
        .rx_data_o   (rx_data),
        .rxrdy_o     (rxrdy),
        .perr_o      (perr),
        .ferr_o      (ferr),
        .ovf_o       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Call right after a falling edge; each bit is held for baud_count clocks.
    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
        int nd;
        nd = eight ? 8 : 7;
        rx = 1'b0;
        repeat (baud_count) @(negedge clk);
        for (int i = 0; i < nd; i++) begin
            rx = data[i];
            repeat (baud_count) @(negedge clk);
        end
        if (pen) begin
            rx = par;
            repeat (baud_count) @(negedge clk);
        end
        rx = stop;
        repeat (baud_count) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clr();
        rxrdy_clr = 1'b1;
        @(negedge clk);
        rxrdy_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_flags(input string tag, input logic [7:0] d, input logic rdy,
                               input logic pe, input logic fe, input logic ov);
        check_eq({tag, ".data"}, {24'd0, rx_data}, {24'd0, d});
        check_eq({tag, ".rxrdy"}, {31'd0, rxrdy}, {31'd0, rdy});
        check_eq({tag, ".perr"}, {31'd0, perr}, {31'd0, pe});
        check_eq({tag, ".ferr"}, {31'd0, ferr}, {31'd0, fe});
        check_eq({tag, ".ovf"}, {31'd0, ovf}, {31'd0, ov});
    endtask

    initial begin
        rst        = 1'b1;
        rx         = 1'b1;
        baud_count = 20'd16;
        eight      = 1'b1;
        pen        = 1'b0;
        ohel       = 1'b0;
        rxrdy_clr  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_flags("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Basic 8N1 frame.
        idle(5);
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(4);
        check_flags("a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_clr();
        check_flags("a5_clr", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

        // Short low glitch is rejected at the half-bit sample.
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(30);
        check_eq("glitch.rxrdy", {31'd0, rxrdy}, 32'd0);
        send_frame(8'h3C, 1'b0, 1'b1);
        idle(4);
        check_flags("3c", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_clr();

        // 7 data bits, odd parity: 0x55 has four ones, so the parity bit is 1.
        eight = 1'b0;
        pen   = 1'b1;
        ohel  = 1'b1;
        idle(5);
        send_frame(8'h55, 1'b1, 1'b1);
        idle(4);
        check_flags("7o1_good", 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_clr();
        send_frame(8'h55, 1'b0, 1'b1);
        idle(4);
        check_flags("7o1_bad", 8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
        pulse_clr();

        // Low stop bit followed by a held-low line: one frame only.
        eight = 1'b1;
        pen   = 1'b0;
        ohel  = 1'b0;
        idle(5);
        send_frame(8'h81, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        idle(200);
        check_flags("break", 8'h81, 1'b1, 1'b0, 1'b1, 1'b0);
        pulse_clr();
        send_frame(8'h42, 1'b0, 1'b1);
        idle(4);
        check_flags("42", 8'h42, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_clr();

        // Overrun.
        send_frame(8'h11, 1'b0, 1'b1);
        idle(4);
        send_frame(8'h22, 1'b0, 1'b1);
        idle(4);
        check_flags("ovf", 8'h22, 1'b1, 1'b0, 1'b0, 1'b1);

        // Completion lands on posedge 155 after the start bit's falling-edge drive
        // (2 sync + 1 idle->start + 8 half bit + 9*16 bits); clear on exactly that edge.
        fork
            send_frame(8'h33, 1'b0, 1'b1);
            begin
                repeat (154) @(posedge clk);
                @(negedge clk);
                rxrdy_clr = 1'b1;
                @(negedge clk);
                rxrdy_clr = 1'b0;
            end
        join
        idle(4);
        check_flags("clr_vs_done", 8'h33, 1'b1, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of the data bits of 0xF0.
        rx = 1'b0;
        repeat (16) @(negedge clk);
        repeat (64) @(negedge clk);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_flags("in_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        idle(100);
        check_eq("abort.rxrdy", {31'd0, rxrdy}, 32'd0);
        send_frame(8'h0F, 1'b0, 1'b1);
        idle(4);
        check_flags("0f", 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #2000000;
        n_err++;
        $display("FAIL timeout: got running, expected finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end

endmodule
